divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 33 +++
 rtl/divider.sv | 119 +++++++++++
 tb/tb_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
// Holds the FSM state type, the operand width, the iteration count and
// the quotient value returned for a zero divisor.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   part_rem  - current partial remainder
//   dividend  - dividend shift register; its MSB feeds the remainder
//   divisor   - divisor magnitude
//   next_rem  - partial remainder after the trial subtraction
//   next_dvd  - dividend shifted left with the new quotient bit in the LSB
//   q_bit     - quotient bit produced by this iteration
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] part_rem,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] next_rem,
    output logic [DIV_WIDTH-1:0] next_dvd,
    output logic                 q_bit
);

    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH+1:0] diff;

    always_comb begin
        shifted = {part_rem, dividend[DIV_WIDTH-1]};
        // One extra bit so a borrow shows up as a set MSB.
        diff    = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = ~diff[DIV_WIDTH+1];
        // Either result is below the divisor, so it fits in DIV_WIDTH bits.
        next_rem = q_bit ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
        next_dvd = {dividend[DIV_WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/divider.sv
// Iterative 32-bit signed/unsigned restoring divider, one bit per clock.
// Ports:
//   mul_clk    - clock, rising edge
//   reset      - synchronous active-high reset
//   div        - level request: high starts/holds, low aborts/releases
//   div_signed - operands are two's complement when high (sampled at capture)
//   x, y       - dividend and divisor (sampled at capture)
//   complete   - results valid for the current request
//   quotient   - x / y truncated toward zero
//   remainder  - x - quotient*y, sign follows the dividend
//
// state | meaning
// IDLE  | waiting for div; captures operands when div is high
// BUSY  | one restoring step per edge, counter counts down to 1
// DONE  | results registered; held until div drops
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mul_clk,
    input  logic             reset,
    input  logic             div,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             complete,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t state, state_n;

    logic [5:0]           cnt;
    logic [DIV_WIDTH-1:0] rem_r, dvd_r, dsr_r;
    logic                 neg_q, neg_r;

    logic [DIV_WIDTH-1:0] x_mag, y_mag;
    logic [DIV_WIDTH-1:0] step_rem, step_dvd;
    logic                 step_q;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign x_mag = (div_signed && x[DIV_WIDTH-1]) ? -x : x;
    assign y_mag = (div_signed && y[DIV_WIDTH-1]) ? -y : y;

    div_step u_step (
        .part_rem (rem_r),
        .dividend (dvd_r),
        .divisor  (dsr_r),
        .next_rem (step_rem),
        .next_dvd (step_dvd),
        .q_bit    (step_q)
    );

    always_ff @(posedge mul_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (div) state_n = (y == '0) ? DONE : BUSY;
            BUSY: begin
                if (!div)          state_n = IDLE;
                else if (cnt == 6'd1) state_n = DONE;
            end
            DONE: if (!div) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            cnt       <= '0;
            rem_r     <= '0;
            dvd_r     <= '0;
            dsr_r     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            complete  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            // complete trails DONE by one edge so it rises with stable results.
            complete <= (state == DONE) && div;
            case (state)
                IDLE: if (div) begin
                    rem_r <= '0;
                    dvd_r <= x_mag;
                    dsr_r <= y_mag;
                    neg_q <= div_signed && (x[DIV_WIDTH-1] ^ y[DIV_WIDTH-1]);
                    neg_r <= div_signed && x[DIV_WIDTH-1];
                    if (y == '0) begin
                        cnt       <= '0;
                        quotient  <= DIV_BY_ZERO_Q;
                        remainder <= x;
                    end else begin
                        cnt <= 6'(DIV_ITERS);
                    end
                end
                BUSY: if (div) begin
                    rem_r <= step_rem;
                    dvd_r <= step_dvd;
                    cnt   <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        quotient  <= neg_q ? -step_dvd : step_dvd;
                        remainder <= neg_r ? -step_rem : step_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_q;
    assign unused_q = step_q;

endmodule

// File: tb/tb_divider.sv
module tb_divider;

    logic        mul_clk = 1'b0;
    logic        reset, div, div_signed;
    logic [31:0] x, y;
    logic        complete;
    logic [31:0] quotient, remainder;

    divider #(.WIDTH(32)) dut (
        .mul_clk    (mul_clk),
        .reset      (reset),
        .div        (div),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .complete   (complete),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 mul_clk = ~mul_clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_q = '0, last_r = '0;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint as_, bs_, qq, rr;
        if (b == 0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (s) begin
            as_ = longint'($signed(a));
            bs_ = longint'($signed(b));
            qq = as_ / bs_;
            rr = as_ % bs_;
            q = qq[31:0];
            r = rr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                        input logic [31:0] r);
        exp_t e;
        e.q = q;
        e.r = r;
        e.lat = (b == 0) ? 1 : 33;
        sb.push_back(e);
    endtask

    // Called just before the capture edge; finishes with div low and the FSM back in IDLE.
    task automatic wait_done();
        exp_t e;
        int   n;
        @(posedge mul_clk); #1;
        chk("complete_low_after_capture", {31'b0, complete}, 32'd0);
        @(negedge mul_clk);
        x = $urandom; y = $urandom; div_signed = $urandom_range(0, 1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge mul_clk); #1;
            if (complete) begin n = i; break; end
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("latency_edges", n, e.lat);
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            for (int i = 0; i < 3; i++) begin
                @(posedge mul_clk); #1;
                chk("hold_complete", {31'b0, complete}, 32'd1);
                chk("hold_quotient", quotient, e.q);
                chk("hold_remainder", remainder, e.r);
            end
            last_q = e.q;
            last_r = e.r;
        end
        @(negedge mul_clk); div = 1'b0;
        @(posedge mul_clk); #1;
        chk("release_complete", {31'b0, complete}, 32'd0);
        chk("release_quotient", quotient, last_q);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] q, input logic [31:0] r);
        @(negedge mul_clk);
        x = a; y = b; div_signed = s; div = 1'b1;
        push(a, b, q, r);
        wait_done();
    endtask

    initial begin
        logic [31:0] mq, mr, ra, rb;
        logic        rs;

        vecs[0] = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2};
        vecs[1] = '{32'hFFFFFFF9, 32'h2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{32'hFFFFFFF9, 32'h2,        1'b0, 32'h7FFFFFFC, 32'h1};
        vecs[3] = '{32'h12345678, 32'h0,        1'b0, 32'hFFFFFFFF, 32'h12345678};
        vecs[4] = '{32'h12345678, 32'h0,        1'b1, 32'hFFFFFFFF, 32'h12345678};
        vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0};
        vecs[6] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h1};
        vecs[7] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'h0};
        vecs[8] = '{32'd5,        32'd9,        1'b0, 32'h0,        32'd5};
        vecs[9] = '{32'h80000000, 32'h0,        1'b1, 32'hFFFFFFFF, 32'h80000000};

        reset = 1'b1; div = 1'b0; div_signed = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge mul_clk);
        #1;
        chk("reset_complete", {31'b0, complete}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        @(negedge mul_clk); reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].x, vecs[i].y, vecs[i].sgn, vecs[i].q, vecs[i].r);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            rs = $urandom_range(0, 1);
            model(ra, rb, rs, mq, mr);
            run_op(ra, rb, rs, mq, mr);
        end

        // Abort after 10 BUSY edges: outputs keep the previous result.
        @(negedge mul_clk);
        x = 32'd100; y = 32'd7; div_signed = 1'b0; div = 1'b1;
        @(posedge mul_clk);
        repeat (10) @(posedge mul_clk);
        @(negedge mul_clk); div = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge mul_clk); #1;
            chk("abort_complete", {31'b0, complete}, 32'd0);
            chk("abort_quotient", quotient, last_q);
            chk("abort_remainder", remainder, last_r);
        end
        run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0);

        // Reset at BUSY edge 20 with div held high, then immediate recapture.
        @(negedge mul_clk);
        x = 32'd100; y = 32'd7; div_signed = 1'b0; div = 1'b1;
        @(posedge mul_clk);
        repeat (19) @(posedge mul_clk);
        @(negedge mul_clk); reset = 1'b1;
        @(posedge mul_clk); #1;
        chk("midbusy_reset_complete", {31'b0, complete}, 32'd0);
        chk("midbusy_reset_quotient", quotient, 32'd0);
        chk("midbusy_reset_remainder", remainder, 32'd0);
        @(negedge mul_clk);
        reset = 1'b0; x = 32'd50; y = 32'd5; div_signed = 1'b0;
        push(32'd50, 32'd5, 32'd10, 32'd0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
